// File: rtl/bank_mapper_sync.sv
// Cartridge bank/mask register block: synchronises the async bus strobes, stages
// register writes, commits them only while the bus is idle, and translates AddrHi.
module bank_mapper_sync #(
  parameter int          NUM_WINDOWS = 4,
  parameter int          BANK_BITS   = 10,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  REG_BASE    = 8'hD0,
  parameter logic [7:0]  LINEAR_REG  = 8'hC0,
  parameter logic [7:0]  MASK_REG    = 8'hE4
) (
  input  logic                   FastClk,
  input  logic                   Reset,
  input  logic                   nSel,
  input  logic                   nIO,
  input  logic                   nWE,
  input  logic                   nOE,
  input  logic [7:0]             RegAddr,
  input  logic [7:0]             WriteData,
  input  logic [3:0]             AddrHi,
  output logic [7:0]             ReadData,
  output logic                   ReadAck,
  output logic [BANK_BITS-1:0]   BankOut,
  output logic [NUM_WINDOWS:0]   WindowHit,
  output logic                   Locked,
  output logic                   Pending
);
  localparam int         HB       = BANK_BITS - 8;
  localparam int         LW       = BANK_BITS - 4;
  localparam logic [7:0] MASK_LO  = MASK_REG;
  localparam logic [7:0] MASK_HI  = MASK_REG + 8'd1;
  localparam logic [7:0] APPLY_A  = MASK_REG + 8'd2;
  localparam logic [7:0] LOCK_A   = MASK_REG + 8'd3;

  logic [SYNC_STAGES-1:0][3:0] sync;  // {nOE, nWE, nIO, nSel} per stage
  logic sn_sel, sn_io, sn_we, sn_oe, unused_oe;
  logic we_q, sel_q, io_q;
  logic [7:0] cap_addr, cap_data;
  logic [NUM_WINDOWS-1:0][BANK_BITS-1:0] stage_bank, act_bank;
  logic [BANK_BITS-1:0] stage_mask, act_mask;
  logic [NUM_WINDOWS-1:0] stage_apply, act_apply;
  logic [7:0] stage_lin, act_lin;
  logic wr_ev, stage_reg, stage_wr, commit;
  logic [BANK_BITS-1:0] bank_d;
  logic [NUM_WINDOWS:0] hit_d;
  logic [LW-1:0] lin_tr;

  assign {sn_oe, sn_we, sn_io, sn_sel} = sync[SYNC_STAGES-1];
  assign unused_oe = sn_oe;
  assign wr_ev  = sn_we & ~we_q & ~sel_q & ~io_q;
  assign stage_wr = wr_ev & stage_reg & ~Locked;
  // A staging write in the same cycle defers the commit to the next idle cycle.
  assign commit = Pending & sn_sel & ~stage_wr;

  always_comb begin
    stage_reg = (cap_addr == LINEAR_REG) || (cap_addr == MASK_LO) ||
                (cap_addr == MASK_HI) || (cap_addr == APPLY_A);
    for (int i = 0; i < NUM_WINDOWS; i++)
      if (cap_addr == 8'(REG_BASE + 2*i) || cap_addr == 8'(REG_BASE + 2*i + 1))
        stage_reg = 1'b1;
  end

  always_ff @(posedge FastClk) begin
    if (Reset) begin
      sync        <= '1;
      we_q        <= 1'b1;
      sel_q       <= 1'b1;
      io_q        <= 1'b1;
      cap_addr    <= '0;
      cap_data    <= '0;
      stage_bank  <= '1;
      act_bank    <= '1;
      stage_mask  <= '1;
      act_mask    <= '1;
      stage_apply <= '1;
      act_apply   <= '1;
      stage_lin   <= 8'hFF;
      act_lin     <= 8'hFF;
      Locked      <= 1'b0;
      Pending     <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], {nOE, nWE, nIO, nSel}};
      we_q  <= sn_we;
      sel_q <= sn_sel;
      io_q  <= sn_io;
      if (!sn_we) begin
        cap_addr <= RegAddr;
        cap_data <= WriteData;
      end
      if (commit) begin
        act_bank  <= stage_bank;
        act_mask  <= stage_mask;
        act_apply <= stage_apply;
        act_lin   <= stage_lin;
        Pending   <= 1'b0;
      end
      if (stage_wr) begin
        Pending <= 1'b1;
        for (int i = 0; i < NUM_WINDOWS; i++) begin
          if (cap_addr == 8'(REG_BASE + 2*i))     stage_bank[i][7:0]           <= cap_data;
          if (cap_addr == 8'(REG_BASE + 2*i + 1)) stage_bank[i][BANK_BITS-1:8] <= cap_data[HB-1:0];
        end
        if (cap_addr == LINEAR_REG) stage_lin                    <= cap_data;
        if (cap_addr == MASK_LO)    stage_mask[7:0]              <= cap_data;
        if (cap_addr == MASK_HI)    stage_mask[BANK_BITS-1:8]    <= cap_data[HB-1:0];
        if (cap_addr == APPLY_A)    stage_apply                  <= cap_data[NUM_WINDOWS-1:0];
      end
      if (wr_ev && cap_addr == LOCK_A && cap_data[0]) Locked <= 1'b1;
    end
  end

  always_comb begin
    bank_d = '0;
    hit_d  = '0;
    lin_tr = LW'(act_lin);
    if (AddrHi > 4'(NUM_WINDOWS)) begin
      hit_d[NUM_WINDOWS] = 1'b1;
      bank_d = {lin_tr, AddrHi} & act_mask;
    end else begin
      for (int i = 0; i < NUM_WINDOWS; i++)
        if (AddrHi == 4'(i + 1)) begin
          hit_d[i] = 1'b1;
          bank_d   = act_apply[i] ? (act_bank[i] & act_mask) : act_bank[i];
        end
    end
  end

  always_ff @(posedge FastClk) begin
    if (Reset) begin
      BankOut   <= '0;
      WindowHit <= '0;
    end else begin
      BankOut   <= bank_d;
      WindowHit <= hit_d;
    end
  end

  // Readback shows staged values so software sees what it wrote before commit.
  always_comb begin
    ReadData = '0;
    ReadAck  = 1'b0;
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      if (RegAddr == 8'(REG_BASE + 2*i)) begin
        ReadAck = 1'b1; ReadData = stage_bank[i][7:0];
      end
      if (RegAddr == 8'(REG_BASE + 2*i + 1)) begin
        ReadAck = 1'b1; ReadData = 8'(stage_bank[i][BANK_BITS-1:8]);
      end
    end
    if (RegAddr == LINEAR_REG) begin ReadAck = 1'b1; ReadData = stage_lin; end
    if (RegAddr == MASK_LO)    begin ReadAck = 1'b1; ReadData = stage_mask[7:0]; end
    if (RegAddr == MASK_HI)    begin ReadAck = 1'b1; ReadData = 8'(stage_mask[BANK_BITS-1:8]); end
    if (RegAddr == APPLY_A)    begin ReadAck = 1'b1; ReadData = 8'(stage_apply); end
    if (RegAddr == LOCK_A)     begin ReadAck = 1'b1; ReadData = {7'd0, Locked}; end
  end
endmodule

// File: tb/tb_bank_mapper_sync.sv
// Directed bench for bank_mapper_sync: per-cycle comparison against a register-level
// model driven by delayed strobe history, plus hand-computed literal expectations.
module tb_bank_mapper_sync;
  localparam int NW = 4;
  localparam int S  = 2;

  logic clk = 0;
  logic Reset, nSel, nIO, nWE, nOE;
  logic [7:0] RegAddr, WriteData, ReadData;
  logic [3:0] AddrHi;
  logic ReadAck, Locked, Pending;
  logic [9:0] BankOut;
  logic [NW:0] WindowHit;

  int total = 0, bad = 0;
  bit chk_on = 0;

  bank_mapper_sync dut (
    .FastClk(clk), .Reset(Reset), .nSel(nSel), .nIO(nIO), .nWE(nWE), .nOE(nOE),
    .RegAddr(RegAddr), .WriteData(WriteData), .AddrHi(AddrHi),
    .ReadData(ReadData), .ReadAck(ReadAck), .BankOut(BankOut),
    .WindowHit(WindowHit), .Locked(Locked), .Pending(Pending)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [S+1:0] h_sel, h_io, h_we;   // [k] = raw strobe sampled k edges ago
  logic [9:0] m_stage[NW], m_act[NW];
  logic [9:0] m_smask, m_amask;
  logic [NW-1:0] m_sapp, m_aapp;
  logic [7:0] m_slin, m_alin, m_caddr, m_cdata;
  logic m_lock, m_pend;
  logic [9:0] m_bank;
  logic [NW:0] m_hit;

  function automatic logic [9:0] xlate(input logic [3:0] a, output logic [NW:0] hit);
    logic [9:0] b;
    hit = '0;
    b = 10'd0;
    if (a == 0) b = 10'd0;
    else if (a <= NW) begin
      hit[a-1] = 1'b1;
      b = m_act[a-1];
      if (m_aapp[a-1]) b = b & m_amask;
    end else begin
      hit[NW] = 1'b1;
      b = 10'((m_alin * 16 + a) % 1024) & m_amask;
    end
    return b;
  endfunction

  always @(posedge clk) begin
    if (Reset) begin
      h_sel = '1; h_io = '1; h_we = '1;
      for (int i = 0; i < NW; i++) begin m_stage[i] = 10'h3FF; m_act[i] = 10'h3FF; end
      m_smask = 10'h3FF; m_amask = 10'h3FF; m_sapp = '1; m_aapp = '1;
      m_slin = 8'hFF; m_alin = 8'hFF; m_caddr = 0; m_cdata = 0;
      m_lock = 0; m_pend = 0; m_bank = 0; m_hit = 0;
    end else begin
      logic wr, streg, cmt;
      int a;
      h_sel = {h_sel[S:0], nSel}; h_io = {h_io[S:0], nIO}; h_we = {h_we[S:0], nWE};
      wr = h_we[S] && !h_we[S+1] && !h_sel[S+1] && !h_io[S+1];
      a = m_caddr;
      streg = (a >= 8'hD0 && a < 8'hD0 + 2*NW) || a == 8'hC0 || (a >= 8'hE4 && a <= 8'hE6);
      streg = wr && streg && !m_lock;
      cmt = m_pend && h_sel[S] && !streg;
      m_bank = xlate(AddrHi, m_hit);
      if (cmt) begin
        for (int i = 0; i < NW; i++) m_act[i] = m_stage[i];
        m_amask = m_smask; m_aapp = m_sapp; m_alin = m_slin; m_pend = 0;
      end
      if (streg) begin
        m_pend = 1;
        if (a >= 8'hD0 && a < 8'hD0 + 2*NW) begin
          if (a % 2 == 0) m_stage[(a-8'hD0)/2] = (m_stage[(a-8'hD0)/2] & 10'h300) | 10'(m_cdata);
          else            m_stage[(a-8'hD0)/2] = (m_stage[(a-8'hD0)/2] & 10'h0FF) | 10'((m_cdata % 4) * 256);
        end
        if (a == 8'hC0) m_slin = m_cdata;
        if (a == 8'hE4) m_smask = (m_smask & 10'h300) | 10'(m_cdata);
        if (a == 8'hE5) m_smask = (m_smask & 10'h0FF) | 10'((m_cdata % 4) * 256);
        if (a == 8'hE6) m_sapp = m_cdata[NW-1:0];
      end
      if (wr && a == 8'hE7 && m_cdata[0]) m_lock = 1;
      if (!h_we[S]) begin m_caddr = RegAddr; m_cdata = WriteData; end
    end
  end

  function automatic logic [8:0] exp_rd(input logic [7:0] a);
    if (a >= 8'hD0 && a < 8'hD0 + 2*NW)
      return {1'b1, (a % 2 == 0) ? m_stage[(a-8'hD0)/2][7:0] : {6'd0, m_stage[(a-8'hD0)/2][9:8]}};
    if (a == 8'hC0) return {1'b1, m_slin};
    if (a == 8'hE4) return {1'b1, m_smask[7:0]};
    if (a == 8'hE5) return {1'b1, 6'd0, m_smask[9:8]};
    if (a == 8'hE6) return {1'b1, 4'd0, m_sapp};
    if (a == 8'hE7) return {1'b1, 7'd0, m_lock};
    return 9'd0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    logic [8:0] r;
    r = exp_rd(RegAddr);
    check("bankout", 32'(BankOut), 32'(m_bank));
    check("windowhit", 32'(WindowHit), 32'(m_hit));
    check("locked", 32'(Locked), 32'(m_lock));
    check("pending", 32'(Pending), 32'(m_pend));
    check("readack", 32'(ReadAck), 32'(r[8]));
    check("readdata", 32'(ReadData), 32'(r[7:0]));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    RegAddr = a; WriteData = d; nIO = 0; nWE = 0;
    step(4);
    nWE = 1;
    step(4);
    nIO = 1;
    step(2);
  endtask

  initial begin
    Reset = 1; nSel = 1; nIO = 1; nWE = 1; nOE = 1;
    RegAddr = 8'h00; WriteData = 8'h00; AddrHi = 4'd2;
    step(2);
    chk_on = 1;
    check("rst_bankout", 32'(BankOut), 32'h0);
    check("rst_hit", 32'(WindowHit), 32'h0);
    check("rst_ack", 32'(ReadAck), 32'h0);
    Reset = 0;
    step(2);
    check("lit_reset_bank", 32'(BankOut), 32'h3FF);
    check("lit_reset_hit", 32'(WindowHit), 32'h02);
    check("lit_reset_lock", 32'(Locked), 32'h0);
    check("lit_reset_pend", 32'(Pending), 32'h0);
    AddrHi = 4'd0; step(1);
    check("lit_addrhi0", 32'({WindowHit, BankOut}), 32'h0);
    AddrHi = 4'd5; step(1);
    check("lit_linear_edge", 32'(BankOut), 32'h3F5);
    AddrHi = 4'd2;

    // staged bank write held until bus idle
    nSel = 0; step(3);
    io_write(8'hD2, 8'h34);
    io_write(8'hD3, 8'h01);
    check("lit_pend_set", 32'(Pending), 32'h1);
    check("lit_bank_held", 32'(BankOut), 32'h3FF);
    RegAddr = 8'hD2; step(1);
    check("lit_readback_d2", 32'({ReadAck, ReadData}), 32'h134);
    nSel = 1; step(S + 2);
    check("lit_commit_bank", 32'(BankOut), 32'h134);
    check("lit_commit_pend", 32'(Pending), 32'h0);

    // mask + apply bits
    nSel = 0; step(3);
    io_write(8'hE4, 8'h0F);
    io_write(8'hE5, 8'h00);
    io_write(8'hE6, 8'h02);
    nSel = 1; step(S + 3);
    check("lit_masked_w1", 32'(BankOut), 32'h004);
    AddrHi = 4'd1; step(1);
    check("lit_unmasked_w0", 32'(BankOut), 32'h3FF);

    // lock drops later writes
    nSel = 0; step(3);
    io_write(8'hE7, 8'h01);
    io_write(8'hD0, 8'h55);
    RegAddr = 8'hD0; step(1);
    check("lit_locked", 32'(Locked), 32'h1);
    check("lit_locked_rd", 32'(ReadData), 32'hFF);
    check("lit_locked_pend", 32'(Pending), 32'h0);
    nSel = 1; step(2);
    Reset = 1; step(1);
    Reset = 0; step(1);
    check("lit_lock_cleared", 32'(Locked), 32'h0);

    // linear region, hi-bit truncation
    nSel = 0; step(3);
    io_write(8'hC0, 8'h02);
    io_write(8'hD3, 8'hFF);
    RegAddr = 8'hD3; step(1);
    check("lit_hi_trunc", 32'(ReadData), 32'h03);
    nSel = 1; AddrHi = 4'hA; step(S + 3);
    check("lit_linear_bank", 32'(BankOut), 32'h02A);
    check("lit_linear_hit", 32'(WindowHit), 32'h10);

    // reset with pending write discards it
    nSel = 0; step(3);
    io_write(8'hD4, 8'h12);
    check("lit_pend_before_rst", 32'(Pending), 32'h1);
    Reset = 1; step(2);
    check("lit_rst_pend", 32'(Pending), 32'h0);
    Reset = 0; nSel = 1; AddrHi = 4'd3; RegAddr = 8'hD4; step(S + 4);
    check("lit_rst_bank", 32'(BankOut), 32'h3FF);
    check("lit_rst_rd", 32'(ReadData), 32'hFF);
    check("lit_rst_nocommit", 32'(Pending), 32'h0);

    step(2);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
